// File: rtl/blowfish_sbox_bank.sv
// Key-loadable bank of four 2**IDX_W x DATA_W S-boxes and the Blowfish F-function
// F(x) = ((S0[a] + S1[b]) ^ S2[c]) + S3[d], one lookup per cycle, result 2 cycles after acceptance.
module blowfish_sbox_bank #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [DATA_W-1:0]    load_data,
  output logic                 load_ready,
  output logic                 load_done,
  output logic                 table_ready,
  input  logic                 f_valid,
  input  logic [4*IDX_W-1:0]   f_in,
  output logic                 f_ready,
  output logic                 f_out_valid,
  output logic [DATA_W-1:0]    f_out,
  output logic                 lookup_err
);

  localparam int DEPTH = 1 << IDX_W;
  localparam int CNT_W = IDX_W + 2;
  localparam logic [CNT_W-1:0] LAST_WORD = '1;

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               wr_en;
  logic               accept;

  logic [DATA_W-1:0]  sbox0 [DEPTH];
  logic [DATA_W-1:0]  sbox1 [DEPTH];
  logic [DATA_W-1:0]  sbox2 [DEPTH];
  logic [DATA_W-1:0]  sbox3 [DEPTH];

  logic [4*IDX_W-1:0] idx_q;
  logic [DATA_W-1:0]  rd0_q;
  logic [DATA_W-1:0]  rd1_q;
  logic [DATA_W-1:0]  rd2_q;
  logic [DATA_W-1:0]  rd3_q;
  logic               v0_q;
  logic               v1_q;
  logic               v2_q;

  // load_start always wins: the word presented alongside it is dropped
  assign wr_en  = (state_q == LOAD) && load_valid && !load_start;
  assign accept = f_valid && f_ready;

  assign load_ready  = (state_q == LOAD);
  assign table_ready = (state_q == READY);
  assign f_ready     = (state_q == READY);
  assign f_out_valid = v2_q;

  always_comb begin
    state_d = state_q;
    if (load_start) begin
      state_d = LOAD;
    end else if (wr_en && (cnt_q == LAST_WORD)) begin
      state_d = READY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      cnt_q      <= '0;
      load_done  <= 1'b0;
      lookup_err <= 1'b0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      f_out      <= '0;
    end else begin
      state_q    <= state_d;
      load_done  <= wr_en && (cnt_q == LAST_WORD);
      lookup_err <= f_valid && !f_ready;
      if (load_start) begin
        cnt_q <= '0;
      end else if (wr_en) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // a new load invalidates every lookup still in the pipe
      v0_q <= accept && !load_start;
      v1_q <= v0_q && !load_start;
      v2_q <= v1_q && !load_start;
      if (v1_q && !load_start) begin
        f_out <= ((rd0_q + rd1_q) ^ rd2_q) + rd3_q;
      end
    end
  end

  // Table storage and datapath registers carry no reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      case (cnt_q[CNT_W-1 -: 2])
        2'd0: sbox0[cnt_q[IDX_W-1:0]] <= load_data;
        2'd1: sbox1[cnt_q[IDX_W-1:0]] <= load_data;
        2'd2: sbox2[cnt_q[IDX_W-1:0]] <= load_data;
        2'd3: sbox3[cnt_q[IDX_W-1:0]] <= load_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q <= f_in;
    end
    rd0_q <= sbox0[idx_q[4*IDX_W-1 -: IDX_W]];
    rd1_q <= sbox1[idx_q[3*IDX_W-1 -: IDX_W]];
    rd2_q <= sbox2[idx_q[2*IDX_W-1 -: IDX_W]];
    rd3_q <= sbox3[idx_q[IDX_W-1:0]];
  end

endmodule

// File: tb/tb_blowfish_sbox_bank.sv
// Scoreboard bench for blowfish_sbox_bank: expected F results queued at request, checked at f_out_valid.
module tb_blowfish_sbox_bank;

  logic        clk;
  logic        rst_n;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_ready;
  logic        load_done;
  logic        table_ready;
  logic        f_valid;
  logic [31:0] f_in;
  logic        f_ready;
  logic        f_out_valid;
  logic [31:0] f_out;
  logic        lookup_err;

  blowfish_sbox_bank #(.DATA_W(32), .IDX_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .load_done(load_done), .table_ready(table_ready),
    .f_valid(f_valid), .f_in(f_in), .f_ready(f_ready),
    .f_out_valid(f_out_valid), .f_out(f_out), .lookup_err(lookup_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  bit          tb_ready = 0;
  logic [31:0] m [4][256];
  logic [31:0] exp_q [$];
  int          acc_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmodel(input logic [31:0] x);
    return ((m[0][x[31:24]] + m[1][x[23:16]]) ^ m[2][x[15:8]]) + m[3][x[7:0]];
  endfunction

  // Scoreboard: every f_out_valid must match the oldest queued request, 2 cycles after acceptance
  always @(negedge clk) begin
    if (rst_n && f_out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_f_out_valid", 32'd1, 32'd0);
      end else begin
        chk("f_out", f_out, exp_q.pop_front());
        chk("latency", cyc - acc_q.pop_front(), 32'd2);
      end
    end
  end

  task automatic fill(input int mode);
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 256; i++) begin
        case (mode)
          2: m[b][i] = (b == 0) ? i : (b == 1) ? (i << 8) : (b == 2) ? 32'd0 : 32'd1;
          5: m[b][i] = 32'd0;
          7: m[b][i] = $urandom;
          default: m[b][i] = 32'hDEAD_0000 | (b << 8) | i;
        endcase
      end
    end
    if (mode == 5) begin
      m[0][255] = 32'hFFFF_FFFF;
      m[1][255] = 32'd2;
    end
  endtask

  // Starts a load with a colliding junk word, streams words; stops early at word 'stop' if >= 0
  task automatic load_table(input int stop);
    @(negedge clk);
    load_start = 1; load_valid = 1; load_data = 32'hBAD0_BAD0; tb_ready = 0;
    @(negedge clk);
    load_start = 0;
    chk("load_ready_in_load", load_ready, 1);
    chk("table_ready_in_load", table_ready, 0);
    for (int w = 0; w < 1024; w++) begin
      if (w == stop) return;
      load_valid = 1;
      load_data = m[w / 256][w % 256];
      @(negedge clk);
      if (w >= 1022) chk("load_done_edge", load_done, (w == 1023) ? 32'd1 : 32'd0);
    end
    load_valid = 0;
    tb_ready = 1;
    chk("table_ready_after_load", table_ready, 1);
    chk("load_ready_after_load", load_ready, 0);
    @(negedge clk);
    chk("load_done_pulse_end", load_done, 0);
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] e);
    f_valid = 1;
    f_in = x;
    chk("f_ready", f_ready, tb_ready);
    if (tb_ready) begin
      exp_q.push_back(e);
      acc_q.push_back(cyc + 1);
    end
    @(negedge clk);
    f_valid = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_table_ready"}, table_ready, 0);
    chk({tag, "_load_ready"}, load_ready, 0);
    chk({tag, "_load_done"}, load_done, 0);
    chk({tag, "_f_ready"}, f_ready, 0);
    chk({tag, "_f_out_valid"}, f_out_valid, 0);
    chk({tag, "_f_out"}, f_out, 0);
    chk({tag, "_lookup_err"}, lookup_err, 0);
  endtask

  initial begin
    rst_n = 0; load_start = 0; load_valid = 0; load_data = 0; f_valid = 0; f_in = 0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1;
    @(negedge clk);
    check_idle("post_reset");

    // Lookup before any load is refused and flagged
    issue(32'h0102_0304, 32'd0);
    chk("err_pulse", lookup_err, 1);
    @(negedge clk);
    chk("err_pulse_end", lookup_err, 0);

    // Reset during load at word 300 discards progress
    fill(1);
    load_table(300);
    rst_n = 0; load_valid = 0;
    #1;
    check_idle("mid_load_reset");
    @(negedge clk);
    rst_n = 1;
    tb_ready = 0;
    @(negedge clk);
    check_idle("after_mid_reset");

    // Full reload, directed lookups and back-to-back stream
    fill(2);
    load_table(-1);
    issue(32'h0102_0304, 32'h0000_0202);
    drain();
    issue(32'h0000_0000, 32'h0000_0001);
    issue(32'h0101_0101, 32'h0000_0102);
    issue(32'h0202_0202, 32'h0000_0203);
    drain();
    chk("f_out_hold", f_out, 32'h0000_0203);

    // Carry out of the top bit is discarded
    fill(5);
    load_table(-1);
    issue(32'hFFFF_0000, 32'h0000_0001);
    drain();

    // Random table, random requests with gaps
    fill(7);
    load_table(-1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        logic [31:0] x;
        x = $urandom;
        issue(x, fmodel(x));
      end else begin
        @(negedge clk);
      end
    end
    drain();

    // load_start right after an accepted lookup kills it
    f_valid = 1; f_in = 32'h1234_5678;
    @(negedge clk);
    f_valid = 0; load_start = 1; tb_ready = 0;
    @(negedge clk);
    load_start = 0;
    chk("kill_table_ready", table_ready, 0);
    chk("kill_load_ready", load_ready, 1);
    chk("kill_f_ready", f_ready, 0);
    for (int i = 0; i < 5; i++) begin
      chk("kill_f_out_valid", f_out_valid, 0);
      @(negedge clk);
    end
    chk("final_queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
